// File: rtl/eeprom_24cxx_master.sv
// eeprom_24cxx_master
//   Bit-serial initiator for 24Cxx-family serial EEPROMs. It performs one
//   single-byte write or one single-byte random read per req/done handshake.
//   It supports X24C01 (mode 0), 24C01..24C16 (mode 1, mode 3 aliases it)
//   and 24C65 (mode 2) addressing.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   en           clock enable; when low, every register holds
//   mode         addressing mode (0/1/2, 3 treated as 1)
//   req          start a transaction (accepted in IDLE with en=1)
//   we, addr,    transaction direction, byte address and write byte,
//   wdata        all latched on accept
//   busy, done   busy between accept and done; done is a one-cycle pulse
//   nack         valid with done; an expected ACK was read high
//   rdata        read byte; updated on done for successful reads only
//   scl          push-pull serial clock
//   sda_o/sda_i  open-drain data drive (1 = released) / resolved bus level
//
// Every bus symbol lasts 4 ticks (t0..t3) of CLK_DIV enabled clocks. The
// transaction is a short list of items (START, BYTE, RECV, STOP). The items
// are indexed by idx_reg and decoded from the latched request by seq_item().
module eeprom_24cxx_master #(
  parameter int CLK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic        req,
  input  logic        we,
  input  logic [12:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        nack,
  output logic [7:0]  rdata,
  output logic        scl,
  output logic        sda_o,
  input  logic        sda_i
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

  localparam logic [1:0] K_START = 2'd0;
  localparam logic [1:0] K_BYTE  = 2'd1;
  localparam logic [1:0] K_RECV  = 2'd2;
  localparam logic [1:0] K_STOP  = 2'd3;

  typedef enum logic [2:0] {IDLE, START, SEND, RECV, STOP, DONE} state_t;

  // The return value is {kind, byte}. Item 0 is always the opening START.
  // Any index past the end of the list yields STOP.
  function automatic logic [9:0] seq_item(input logic [2:0] idx, input logic wr,
                                          input logic [1:0] md, input logic [12:0] a,
                                          input logic [7:0] wd);
    logic [9:0] it;
    it = {K_STOP, 8'h00};
    if (idx == 3'd0) begin
      it = {K_START, 8'h00};
    end else begin
      case ({wr, md})
        3'b100: case (idx)            // X24C01 write
          3'd1: it = {K_BYTE, a[6:0], 1'b0};
          3'd2: it = {K_BYTE, wd};
          default: ;
        endcase
        3'b101: case (idx)            // 24C01..16 write
          3'd1: it = {K_BYTE, 4'b1010, a[10:8], 1'b0};
          3'd2: it = {K_BYTE, a[7:0]};
          3'd3: it = {K_BYTE, wd};
          default: ;
        endcase
        3'b110: case (idx)            // 24C65 write
          3'd1: it = {K_BYTE, 8'hA0};
          3'd2: it = {K_BYTE, 3'b000, a[12:8]};
          3'd3: it = {K_BYTE, a[7:0]};
          3'd4: it = {K_BYTE, wd};
          default: ;
        endcase
        3'b000: case (idx)            // X24C01 read
          3'd1: it = {K_BYTE, a[6:0], 1'b1};
          3'd2: it = {K_RECV, 8'h00};
          default: ;
        endcase
        3'b001: case (idx)            // 24C01..16 random read
          3'd1: it = {K_BYTE, 4'b1010, a[10:8], 1'b0};
          3'd2: it = {K_BYTE, a[7:0]};
          3'd3: it = {K_START, 8'h00};
          3'd4: it = {K_BYTE, 4'b1010, a[10:8], 1'b1};
          3'd5: it = {K_RECV, 8'h00};
          default: ;
        endcase
        3'b010: case (idx)            // 24C65 random read
          3'd1: it = {K_BYTE, 8'hA0};
          3'd2: it = {K_BYTE, 3'b000, a[12:8]};
          3'd3: it = {K_BYTE, a[7:0]};
          3'd4: it = {K_START, 8'h00};
          3'd5: it = {K_BYTE, 8'hA1};
          3'd6: it = {K_RECV, 8'h00};
          default: ;
        endcase
        default: ;
      endcase
    end
    return it;
  endfunction

  state_t         state_reg, state_next;
  logic [TW-1:0]  tick_reg, tick_next;
  logic [1:0]     phase_reg, phase_next;
  logic [3:0]     bit_reg, bit_next;
  logic [2:0]     idx_reg, idx_next;
  logic [7:0]     shift_reg, shift_next;
  logic [7:0]     rx_reg, rx_next;
  logic           ack_reg, ack_next;
  logic           we_reg, we_next;
  logic [1:0]     mode_reg, mode_next;
  logic [12:0]    addr_reg, addr_next;
  logic [7:0]     wdata_reg, wdata_next;
  logic           nack_reg, nack_next;
  logic [7:0]     rdata_reg, rdata_next;

  logic           tick_end, sym_end, sample_pt, scl_mid;
  logic [9:0]     next_item;

  assign tick_end  = (tick_reg == TICK_LAST);
  assign sym_end   = tick_end && (phase_reg == 2'd3);
  assign sample_pt = tick_end && (phase_reg == 2'd2);   // last clock of t2
  assign scl_mid   = (phase_reg == 2'd1) || (phase_reg == 2'd2);

  assign busy  = (state_reg != IDLE) && (state_reg != DONE);
  assign done  = (state_reg == DONE);
  assign nack  = nack_reg;
  assign rdata = rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      phase_reg <= 2'd0;
      bit_reg   <= 4'd0;
      idx_reg   <= 3'd0;
      shift_reg <= 8'h00;
      rx_reg    <= 8'h00;
      ack_reg   <= 1'b0;
      we_reg    <= 1'b0;
      mode_reg  <= 2'd0;
      addr_reg  <= 13'd0;
      wdata_reg <= 8'h00;
      nack_reg  <= 1'b0;
      rdata_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      phase_reg <= phase_next;
      bit_reg   <= bit_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      rx_reg    <= rx_next;
      ack_reg   <= ack_next;
      we_reg    <= we_next;
      mode_reg  <= mode_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      nack_reg  <= nack_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    phase_next = phase_reg;
    bit_next   = bit_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    rx_next    = rx_reg;
    ack_next   = ack_reg;
    we_next    = we_reg;
    mode_next  = mode_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    nack_next  = nack_reg;
    rdata_next = rdata_reg;
    scl        = 1'b1;
    sda_o      = 1'b1;
    next_item  = seq_item(idx_reg + 3'd1, we_reg, mode_reg, addr_reg, wdata_reg);

    // The bus levels are decoded from registered state only, so they hold
    // automatically while en is low.
    case (state_reg)
      START: begin
        scl   = scl_mid;
        sda_o = (phase_reg < 2'd2);
      end
      SEND: begin
        scl   = scl_mid;
        sda_o = (bit_reg == 4'd8) ? 1'b1 : shift_reg[7];  // release for ACK
      end
      RECV: scl = scl_mid;                                // bit 9 sends NACK (1)
      STOP: begin
        scl   = (phase_reg != 2'd0);
        sda_o = phase_reg[1];
      end
      default: ;
    endcase

    if (en) begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            state_next = START;
            tick_next  = '0;
            phase_next = 2'd0;
            bit_next   = 4'd0;
            idx_next   = 3'd0;
            we_next    = we;
            mode_next  = (mode == 2'd3) ? 2'd1 : mode;
            addr_next  = addr;
            wdata_next = wdata;
            nack_next  = 1'b0;
          end
        end
        DONE: state_next = IDLE;
        default: begin
          tick_next = tick_end ? '0 : tick_reg + 1'b1;
          if (tick_end) phase_next = phase_reg + 2'd1;
          if (sample_pt && state_reg == SEND) ack_next = sda_i;
          if (sample_pt && state_reg == RECV && bit_reg != 4'd8)
            rx_next = {rx_reg[6:0], sda_i};
          if (sym_end) begin
            if (state_reg == STOP) begin
              state_next = DONE;
              if (!we_reg && !nack_reg) rdata_next = rx_reg;
            end else if ((state_reg == SEND || state_reg == RECV) && bit_reg != 4'd8) begin
              bit_next   = bit_reg + 4'd1;
              shift_next = {shift_reg[6:0], 1'b0};
            end else if (state_reg == SEND && ack_reg) begin
              // ACK read high: abandon the remaining items and close the bus
              state_next = STOP;
              nack_next  = 1'b1;
            end else begin
              idx_next   = idx_reg + 3'd1;
              bit_next   = 4'd0;
              shift_next = next_item[7:0];
              case (next_item[9:8])
                K_START: state_next = START;
                K_BYTE:  state_next = SEND;
                K_RECV:  state_next = RECV;
                default: state_next = STOP;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/eeprom_24cxx_master.md
Name: eeprom_24cxx_master

Overview:
- I2C-style initiator that performs single-byte write and random-read transactions on a 24Cxx-family serial EEPROM.
- Used by save-RAM test harnesses and by the cartridge-debug path to drive the on-board EEPROM responder over scl/sda.
- Three addressing modes: X24C01, 24C01–24C16, and 24C65.
- A request/done handshake on the host side becomes a bit-serial bus sequence with ACK checking.

Parameters:
- CLK_DIV, default 16: clk-enable cycles per quarter-symbol tick. Legal range is 8 or more, so the responder's 4-stage input filter resolves every edge.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  clock enable; when low, all state, counters and outputs hold
- mode  in  2  0 = X24C01, 1 = 24C01–24C16, 2 = 24C65, 3 = treated as 1
- req  in  1  start a transaction; sampled only in IDLE with en=1
- we  in  1  1 = write, 0 = read; latched with req
- addr  in  13  byte address; latched with req
- wdata  in  8  write byte; latched with req
- busy  out  1  high from the cycle after req is accepted until done
- done  out  1  one-cycle pulse at the end of a transaction
- nack  out  1  valid with done; 1 = an expected ACK read high
- rdata  out  8  read result; updated on done for a successful read only
- scl  out  1  serial clock, push-pull
- sda_o  out  1  open-drain drive; 1 = released
- sda_i  in  1  resolved bus level (wired-AND)

Behaviour:
- Reset values: scl=1, sda_o=1, busy=0, done=0, nack=0, rdata=0, state=IDLE.
- Reset mid-transaction: the bus is released on the next clk and no STOP is generated.
- Timing:
  - tick = CLK_DIV enabled clocks.
  - Every symbol is 4 ticks, t0..t3.
  - Tick counter and symbol counter advance only when en=1.
- START / repeated-START symbol:
  - t0: SCL=0, SDA=1
  - t1: SCL=1, SDA=1
  - t2: SCL=1, SDA=0
  - t3: SCL=0, SDA=0
- BIT symbol:
  - t0: SCL=0, drive data (MSB first)
  - t1, t2: SCL=1
  - sda_i is sampled on the last clock of t2
  - t3: SCL=0
- STOP symbol:
  - t0: SCL=0, SDA=0
  - t1: SCL=1, SDA=0
  - t2: SCL=1, SDA=1
  - t3: SCL=1, SDA=1
- Byte symbol group: 8 data bits plus a 9th ACK bit.
  - Sending: master releases SDA in bit 9; a sampled 1 means NACK.
  - Receiving: master releases SDA for bits 1–8 and drives 1 (NACK) in bit 9. Only single-byte reads are supported.
- States: IDLE, START, SEND, RECV, STOP, DONE. A byte-sequence index selects the next byte.
- Write sequences:
  - mode 0: S, {addr[6:0],0}, wdata, P
  - mode 1: S, {1010,addr[10:8],0}, addr[7:0], wdata, P
  - mode 2: S, {1010000,0}, {000,addr[12:8]}, addr[7:0], wdata, P
- Read sequences:
  - mode 0: S, {addr[6:0],1}, RECV, P
  - mode 1: S, dev-W, addr[7:0], S, {1010,addr[10:8],1}, RECV, P
  - mode 2: S, dev-W, hi, lo, S, {1010000,1}, RECV, P
- Symbol counts:
  - write: 20 / 29 / 38 for modes 0 / 1 / 2
  - read: 20 / 39 / 48 for modes 0 / 1 / 2
- Latency: done asserts exactly symbols×4×CLK_DIV enabled clocks after the accept cycle.
- NACK on any sent byte:
  - skip the remaining bytes and go straight to STOP;
  - done with nack=1;
  - rdata unchanged.
- DONE:
  - busy=0 and done=1 in the same cycle, then IDLE.
  - A new req on the cycle after done is accepted.
- req while busy is ignored, with no queueing.
- req while en=0 is not accepted.
- Address bits above the mode's width are not transmitted.

Test Plan:
- CLK_DIV=8, mode 1, we=1, addr=0x2A5, wdata=0x5C, behavioural 24Cxx slave model → bytes A4, A5, 5C all ACKed; done at accept+928; nack=0; slave byte 0x2A5 = 0x5C.
- Then a mode 1 read of addr 0x2A5 → repeated START seen, dev byte A5; rdata=0x5C; done at accept+1248; master drives NACK on the 9th bit.
- Mode 0: write 0x33 to 0x7F, then read it back → first bytes FE / FF; rdata=0x33; each done at accept+640.
- Mode 2: write 0xC3 to 0x1ABC, then read → bytes A0, 1A, BC; rdata=0xC3; done at accept+1216 for the write and accept+1536 for the read.
- No slave (sda_i tied 1): write in mode 1 → STOP issued after the first byte; done with nack=1 at accept+(1+9+1)×32=352; rdata unchanged.
- Assert rst mid-byte → next clk scl=1, sda_o=1, busy=0. Hold en=0 for 50 clocks mid-bit → scl/sda frozen and done delayed by exactly 50 clocks.
